// File: rtl/l2_trace_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : l2_trace_dispatcher
// Description : Buffers decoded trace commands in an in-order FIFO, presents
//               cache requests (codes 0-6) over a valid/ready handshake with
//               the address split into tag/index/offset, turns clear (8) and
//               print (9) entries into one-cycle pulses in trace order, and
//               keeps per-class statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
module l2_trace_dispatcher #(
  parameter int ADDRESS_SIZE = 32,
  parameter int COMMAND_SIZE = 32,
  parameter int DEPTH        = 4,
  parameter int OFFSET_BITS  = 6,
  parameter int INDEX_BITS   = 14
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        cmd_valid,
  output logic                                        cmd_ready,
  input  logic [COMMAND_SIZE-1:0]                     cmd_code,
  input  logic [ADDRESS_SIZE-1:0]                     cmd_address,
  output logic                                        req_valid,
  input  logic                                        req_ready,
  output logic [2:0]                                  req_op,
  output logic                                        req_snoop,
  output logic [ADDRESS_SIZE-INDEX_BITS-OFFSET_BITS-1:0] req_tag,
  output logic [INDEX_BITS-1:0]                       req_index,
  output logic [OFFSET_BITS-1:0]                      req_offset,
  output logic                                        clear_pulse,
  output logic                                        print_pulse,
  output logic [31:0]                                 read_count,
  output logic [31:0]                                 write_count,
  output logic [31:0]                                 instr_count,
  output logic [31:0]                                 snoop_count,
  output logic [31:0]                                 illegal_count
);

  localparam int TAG_BITS = ADDRESS_SIZE - INDEX_BITS - OFFSET_BITS;
  localparam int PTR_W    = $clog2(DEPTH);
  // Only legal codes (0-6, 8, 9) are stored, so four bits suffice.
  localparam int CODE_W   = 4;

  localparam logic [CODE_W-1:0] CODE_MAX_REQ = 4'd6;
  localparam logic [CODE_W-1:0] CODE_CLEAR   = 4'd8;
  localparam logic [CODE_W-1:0] CODE_PRINT   = 4'd9;

  logic [CODE_W-1:0]       code_mem [DEPTH];
  logic [ADDRESS_SIZE-1:0] addr_mem [DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [PTR_W:0]          occupancy;

  logic                    accept;
  logic                    in_read;
  logic                    in_write;
  logic                    in_instr;
  logic                    in_snoop;
  logic                    in_ctl;
  logic                    in_illegal;
  logic                    push;

  logic [CODE_W-1:0]       head_code;
  logic [ADDRESS_SIZE-1:0] head_addr;
  logic                    head_present;
  logic                    head_is_req;
  logic                    head_is_ctl;
  logic                    pop;
  logic                    clear_pop;

  // Input-side classification of the presented command.
  always_comb begin
    // Readiness uses registered occupancy only; a pop in the same cycle does
    // not open a slot until the next cycle.
    cmd_ready  = !rst && (occupancy < (PTR_W+1)'(DEPTH));
    accept     = cmd_valid && cmd_ready;
    in_read    = (cmd_code == COMMAND_SIZE'(0));
    in_write   = (cmd_code == COMMAND_SIZE'(1));
    in_instr   = (cmd_code == COMMAND_SIZE'(2));
    in_snoop   = (cmd_code >= COMMAND_SIZE'(3)) && (cmd_code <= COMMAND_SIZE'(6));
    in_ctl     = (cmd_code == COMMAND_SIZE'(8)) || (cmd_code == COMMAND_SIZE'(9));
    in_illegal = (cmd_code > COMMAND_SIZE'(6)) && !in_ctl;
    push       = accept && !in_illegal;
  end

  // Head-of-queue decode and request presentation.
  always_comb begin
    head_code    = code_mem[rd_ptr];
    head_addr    = addr_mem[rd_ptr];
    head_present = (occupancy != '0);
    head_is_req  = head_present && (head_code <= CODE_MAX_REQ);
    head_is_ctl  = head_present && ((head_code == CODE_CLEAR) || (head_code == CODE_PRINT));
    // Control entries never wait for the cache; they retire on the next edge.
    pop          = (head_is_req && req_ready) || head_is_ctl;
    clear_pop    = head_is_ctl && (head_code == CODE_CLEAR);

    req_valid    = head_is_req;
    req_op       = head_code[2:0];
    req_snoop    = (head_code[2:0] >= 3'd3);
    req_tag      = head_addr[ADDRESS_SIZE-1 -: TAG_BITS];
    req_index    = head_addr[OFFSET_BITS +: INDEX_BITS];
    req_offset   = head_addr[OFFSET_BITS-1:0];
  end

  // FIFO storage and pointer/occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        code_mem[i] <= '0;
        addr_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        code_mem[wr_ptr] <= cmd_code[CODE_W-1:0];
        addr_mem[wr_ptr] <= cmd_address;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   occupancy <= occupancy + (PTR_W+1)'(1);
        2'b01:   occupancy <= occupancy - (PTR_W+1)'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Control pulses are registered so they appear the cycle after the pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clear_pulse <= 1'b0;
      print_pulse <= 1'b0;
    end else begin
      clear_pulse <= clear_pop;
      print_pulse <= head_is_ctl && (head_code == CODE_PRINT);
    end
  end

  // Statistics counters; a clear pop zeroes them but still counts a
  // command accepted on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_count    <= '0;
      write_count   <= '0;
      instr_count   <= '0;
      snoop_count   <= '0;
      illegal_count <= '0;
    end else if (clear_pop) begin
      read_count    <= 32'(accept && in_read);
      write_count   <= 32'(accept && in_write);
      instr_count   <= 32'(accept && in_instr);
      snoop_count   <= 32'(accept && in_snoop);
      illegal_count <= 32'(accept && in_illegal);
    end else begin
      read_count    <= read_count    + 32'(accept && in_read);
      write_count   <= write_count   + 32'(accept && in_write);
      instr_count   <= instr_count   + 32'(accept && in_instr);
      snoop_count   <= snoop_count   + 32'(accept && in_snoop);
      illegal_count <= illegal_count + 32'(accept && in_illegal);
    end
  end

endmodule
`default_nettype wire
